net_word_capture: RTL and testbench

NET_WORD_CAPTURE -- requirements
Module: net_word_capture

---
 rtl/net_capture_pkg.sv | 12 +
 rtl/net_word_sanitize.sv | 23 ++
 rtl/net_word_capture.sv | 103 ++++++++++
 tb/tb_net_word_capture.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/net_capture_pkg.sv
// Shared types for the net word capture FIFO: the 9-bit word layout and FIFO occupancy states.
package net_capture_pkg;
    localparam int WORD_W = 9;

    typedef logic [3:1][2:4] word_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;
endpackage

// File: rtl/net_word_sanitize.sv
// Turns a possibly unresolved wor-net word into a clean 2-state word.
// Every X/Z bit becomes 0, and a flag reports whether any such bit was seen.
module net_word_sanitize
    import net_capture_pkg::*;
(
    input  word_t raw,
    output word_t clean,
    output logic  unknown
);
    logic [WORD_W-1:0] raw_flat;
    logic [WORD_W-1:0] clean_flat;

    assign raw_flat = raw;
    assign clean    = clean_flat;

    always_comb begin
        clean_flat = '0;
        for (int b = 0; b < WORD_W; b++) begin
            clean_flat[b] = (raw_flat[b] === 1'b1);
        end
        unknown = $isunknown(raw);
    end
endmodule

// File: rtl/net_word_capture.sv
// Captures sanitized words from an upstream wor net into a small FIFO.
// It also keeps a running signature of accepted words and counts stalled offers.
module net_word_capture
    import net_capture_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [8:0]  SIG_INIT = 9'h000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:1][2:4]          in_word,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [3:1][2:4]          out_word,
    output logic                     out_unknown,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [8:0]               sig,
    output logic [7:0]               stall_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [8:0]      sig_q, sig_d;
    logic [7:0]      stall_q, stall_d;
    word_t           mem_q [DEPTH];
    logic [DEPTH-1:0] unk_mem_q;

    word_t           san_word;
    logic            san_unknown;
    logic            acc, pop;

    net_word_sanitize u_sanitize (
        .raw     (in_word),
        .clean   (san_word),
        .unknown (san_unknown)
    );

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is never reset, so the head is masked while the FIFO is empty.
    assign out_word    = out_valid ? mem_q[rptr_q] : '0;
    assign out_unknown = out_valid ? unk_mem_q[rptr_q] : 1'b0;
    assign count       = count_q;
    assign sig         = sig_q;
    assign stall_cnt   = stall_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wptr_d  = acc ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        sig_d   = acc ? ({sig_q[7:0], sig_q[8]} ^ san_word) : sig_q;
        stall_d = (in_valid && !in_ready && stall_q != 8'hFF) ? stall_q + 8'd1 : stall_q;

        case ({acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            EMPTY:  if (acc) state_d = ACTIVE;
            ACTIVE: begin
                if (acc && !pop && count_q == CW'(DEPTH - 1))
                    state_d = FULL;
                else if (pop && !acc && count_q == CW'(1))
                    state_d = EMPTY;
            end
            FULL:   if (pop) state_d = ACTIVE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            sig_q   <= SIG_INIT;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            sig_q   <= sig_d;
            stall_q <= stall_d;
            if (acc) begin
                mem_q[wptr_q]     <= san_word;
                unk_mem_q[wptr_q] <= san_unknown;
            end
        end
    end
endmodule

// File: tb/tb_net_word_capture.sv
// Directed bench for net_word_capture: inputs change on the falling edge, outputs are checked there too.
module tb_net_word_capture;
    logic                 clk;
    logic                 rst_n;
    logic [3:1][2:4]      in_word;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:1][2:4]      out_word;
    logic                 out_unknown;
    logic                 out_valid;
    logic                 out_ready;
    logic [2:0]           count;
    logic [8:0]           sig;
    logic [7:0]           stall_cnt;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_sig;

    net_word_capture #(.DEPTH(4), .SIG_INIT(9'h000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_word     (in_word),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_word    (out_word),
        .out_unknown (out_unknown),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .sig         (sig),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] sig_next(input logic [8:0] s, input logic [8:0] w);
        return {s[7:0], s[8]} ^ w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = '0;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (sig !== 9'h000) begin bad++; $display("FAIL reset_sig got=%h want=000", sig); end
        total++; if (stall_cnt !== 8'h00) begin bad++; $display("FAIL reset_stall got=%h want=00", stall_cnt); end
        total++; if (out_word !== 9'h000 || out_unknown !== 1'b0) begin
            bad++; $display("FAIL reset_out_word got=%h/%b want=000/0", out_word, out_unknown);
        end
        @(negedge clk); rst_n = 1'b1;
        exp_sig = 9'h000;
    endtask

    task automatic test_basic();
        in_word = 9'h1A5; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        exp_sig = sig_next(exp_sig, 9'h1A5);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
        total++; if (out_word !== 9'h1A5) begin bad++; $display("FAIL basic_word got=%h want=1a5", out_word); end
        total++; if (out_unknown !== 1'b0) begin bad++; $display("FAIL basic_unknown got=%b want=0", out_unknown); end
        total++; if (sig !== 9'h1A5) begin bad++; $display("FAIL basic_sig got=%h want=1a5", sig); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", count); end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            bad++; $display("FAIL basic_pop got=%b/%0d want=0/0", out_valid, count);
        end
    endtask

    task automatic test_unknown();
        logic [8:0] w, exp_w;
        logic       exp_u;
        w = 9'h1FF; w[8] = 1'bx; w[0] = 1'bz;
        // Expected values follow the driven bits, so a 2-state simulator that resolves X/Z is still judged fairly.
        for (int b = 0; b < 9; b++) exp_w[b] = (w[b] === 1'b1);
        exp_u = $isunknown(w);
        in_word = w; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; in_word = '0;
        exp_sig = sig_next(exp_sig, exp_w);
        total++; if (out_word !== exp_w) begin bad++; $display("FAIL unk_word got=%h want=%h", out_word, exp_w); end
        total++; if (out_unknown !== exp_u) begin bad++; $display("FAIL unk_flag got=%b want=%b", out_unknown, exp_u); end
        total++; if (sig !== exp_sig) begin bad++; $display("FAIL unk_sig got=%h want=%h", sig, exp_sig); end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_full_stall();
        logic [8:0] words [5];
        words[0] = 9'h011; words[1] = 9'h122; words[2] = 9'h033; words[3] = 9'h144; words[4] = 9'h055;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_word = words[i]; in_valid = 1'b1;
            @(negedge clk);
            exp_sig = sig_next(exp_sig, words[i]);
            total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count%0d got=%0d want=%0d", i, count, i + 1); end
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
        in_word = words[4];
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++; if (stall_cnt !== 8'(k)) begin bad++; $display("FAIL stall%0d got=%0d want=%0d", k, stall_cnt, k); end
        end
        total++; if (sig !== exp_sig || count !== 3'd4) begin
            bad++; $display("FAIL full_hold got=%h/%0d want=%h/4", sig, count, exp_sig);
        end
        // First drain cycle keeps the offer up: a pop on a full FIFO must not let it in.
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            total++; if (out_valid !== 1'b1 || out_word !== words[j]) begin
                bad++; $display("FAIL drain%0d got=%b/%h want=1/%h", j, out_valid, out_word, words[j]);
            end
            @(negedge clk);
            if (j == 0) begin
                in_valid = 1'b0;
                total++; if (count !== 3'd3 || stall_cnt !== 8'd4) begin
                    bad++; $display("FAIL full_pop_no_acc got=%0d/%0d want=3/4", count, stall_cnt);
                end
            end
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || count !== 3'd0 || sig !== exp_sig) begin
            bad++; $display("FAIL drain_end got=%b/%0d/%h want=0/0/%h", out_valid, count, sig, exp_sig);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] seq [5];
        seq[0] = 9'h0A1; seq[1] = 9'h1B2; seq[2] = 9'h0C3; seq[3] = 9'h1D4; seq[4] = 9'h0E5;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_word = seq[i]; in_valid = 1'b1;
            @(negedge clk);
            exp_sig = sig_next(exp_sig, seq[i]);
        end
        total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_pre got=%0d want=2", count); end
        for (int k = 0; k < 3; k++) begin
            in_word = seq[k + 2]; in_valid = 1'b1; out_ready = 1'b1;
            total++; if (out_word !== seq[k]) begin bad++; $display("FAIL b2b_head%0d got=%h want=%h", k, out_word, seq[k]); end
            @(negedge clk);
            exp_sig = sig_next(exp_sig, seq[k + 2]);
            total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count%0d got=%0d want=2", k, count); end
        end
        in_valid = 1'b0;
        for (int k = 3; k < 5; k++) begin
            total++; if (out_word !== seq[k]) begin bad++; $display("FAIL b2b_tail%0d got=%h want=%h", k, out_word, seq[k]); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++; if (count !== 3'd0 || sig !== exp_sig) begin
            bad++; $display("FAIL b2b_end got=%0d/%h want=0/%h", count, sig, exp_sig);
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_word = 9'(i + 9'h100); in_valid = 1'b1;
            @(negedge clk);
        end
        // stall_cnt starts at 4 from the earlier full test; 250 more stalls land one short of saturation.
        repeat (250) @(negedge clk);
        total++; if (stall_cnt !== 8'hFE) begin bad++; $display("FAIL sat_pre got=%h want=fe", stall_cnt); end
        @(negedge clk);
        total++; if (stall_cnt !== 8'hFF) begin bad++; $display("FAIL sat_hit got=%h want=ff", stall_cnt); end
        repeat (49) @(negedge clk);
        total++; if (stall_cnt !== 8'hFF) begin bad++; $display("FAIL sat_hold got=%h want=ff", stall_cnt); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL sat_pop got=%0d want=3", count); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_word = 9'h0F0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            bad++; $display("FAIL mid_reset got=%b/%0d want=0/0", out_valid, count);
        end
        total++; if (sig !== 9'h000 || stall_cnt !== 8'h00 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_reset_regs got=%h/%h/%b want=000/00/1", sig, stall_cnt, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        exp_sig = 9'h000;
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unknown();
        test_full_stall();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
